am2901_slice: RTL and testbench

- 4-bit bipolar-style ALU bit slice equivalent to the Am2901.
- Contains a 16x4 dual-read register file, a Q register, an 8-function ALU, an 8-way operand source selector and shift/destination logic.
- Two slices cascade through the carry and shift pins to build the 8-bit CPU datapath.
- Instruction fields come directly from the microcode pipeline.

---
 rtl/am2901_slice_if.sv | 29 ++
 rtl/am2901_slice.sv | 69 ++++++
 tb/tb_am2901_slice.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/am2901_slice_if.sv
// am2901_slice_if: microcode, operand, status and shift-cascade signals of one Am2901 slice.
// The p_n/g_n lookahead outputs exist only when AM2901_LOOKAHEAD_EN is defined.
interface am2901_slice_if;
    logic [3:0] din, a_addr, b_addr, yout;
    logic [2:0] src, op, dest;
    logic cin, cout, f0, f3, ovr;
    logic q0_in, ram0_in, q3_in, ram3_in;
    logic q0_out, ram0_out, q3_out, ram3_out;
`ifdef AM2901_LOOKAHEAD_EN
    logic p_n, g_n;
    modport master (
        output din, a_addr, b_addr, src, op, dest, cin, q0_in, ram0_in, q3_in, ram3_in,
        input yout, cout, f0, f3, ovr, q0_out, ram0_out, q3_out, ram3_out, p_n, g_n
    );
    modport slave (
        input din, a_addr, b_addr, src, op, dest, cin, q0_in, ram0_in, q3_in, ram3_in,
        output yout, cout, f0, f3, ovr, q0_out, ram0_out, q3_out, ram3_out, p_n, g_n
    );
`else
    modport master (
        output din, a_addr, b_addr, src, op, dest, cin, q0_in, ram0_in, q3_in, ram3_in,
        input yout, cout, f0, f3, ovr, q0_out, ram0_out, q3_out, ram3_out
    );
    modport slave (
        input din, a_addr, b_addr, src, op, dest, cin, q0_in, ram0_in, q3_in, ram3_in,
        output yout, cout, f0, f3, ovr, q0_out, ram0_out, q3_out, ram3_out
    );
`endif
endinterface

// File: rtl/am2901_slice.sv
// am2901_slice: 4-bit Am2901-style ALU slice with 16x4 dual-read register file and Q register.
// Define AM2901_LOOKAHEAD_EN to add active-low p_n/g_n outputs for an Am2902 lookahead unit.
module am2901_slice (
    input logic clock,
    input logic reset_n,
    am2901_slice_if.slave bus
);
    logic [3:0] ram [16];
    logic [3:0] q, a, b, r, s, rr, ss, f, ram_d;
    logic [4:0] sum;
    logic arith, c3, ram_we;
    assign a = ram[bus.a_addr];
    assign b = ram[bus.b_addr];
    always_comb
        case (bus.src)
            3'd0: {r, s} = {a, q};
            3'd1: {r, s} = {a, b};
            3'd2: {r, s} = {4'd0, q};
            3'd3: {r, s} = {4'd0, b};
            3'd4: {r, s} = {4'd0, a};
            3'd5: {r, s} = {bus.din, a};
            3'd6: {r, s} = {bus.din, q};
            default: {r, s} = {bus.din, 4'd0};
        endcase
    // Subtraction is done by inverting one operand; cin supplies the +1.
    assign arith = bus.op < 3'd3;
    assign rr = (bus.op == 3'd1) ? ~r : r;
    assign ss = (bus.op == 3'd2) ? ~s : s;
    assign sum = {1'b0, rr} + {1'b0, ss} + {4'd0, bus.cin};
    assign c3 = sum[3] ^ rr[3] ^ ss[3];
    always_comb
        case (bus.op)
            3'd3: f = r | s;
            3'd4: f = r & s;
            3'd5: f = ~r & s;
            3'd6: f = r ^ s;
            3'd7: f = ~(r ^ s);
            default: f = sum[3:0];
        endcase
    assign bus.cout = arith & sum[4];
    assign bus.ovr = arith & (c3 ^ sum[4]);
    assign bus.f0 = f == 4'd0;
    assign bus.f3 = f[3];
    assign bus.yout = (bus.dest == 3'd2) ? a : f;
    assign bus.ram0_out = f[0];
    assign bus.ram3_out = f[3];
    assign bus.q0_out = q[0];
    assign bus.q3_out = q[3];
`ifdef AM2901_LOOKAHEAD_EN
    logic [3:0] p, g;
    assign p = rr | ss;
    assign g = rr & ss;
    assign bus.p_n = ~(arith & (&p));
    assign bus.g_n = ~(arith & (g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0])));
`endif
    // dest 4/5 shift down toward bit 0, dest 6/7 shift up toward bit 3.
    assign ram_d = bus.dest[2] ? (bus.dest[1] ? {f[2:0], bus.ram0_in} : {bus.ram3_in, f[3:1]}) : f;
    assign ram_we = bus.dest[2] | bus.dest[1];
    always_ff @(posedge clock)
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) ram[i] <= '0;
            q <= '0;
        end else begin
            if (ram_we) ram[bus.b_addr] <= ram_d;
            if (bus.dest == 3'd0) q <= f;
            else if (bus.dest == 3'd4) q <= {bus.q3_in, q[3:1]};
            else if (bus.dest == 3'd6) q <= {q[2:0], bus.q0_in};
        end
endmodule

// File: tb/tb_am2901_slice.sv
// tb_am2901_slice: scoreboard bench for one slice plus a two-slice carry cascade.
module tb_am2901_slice;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    am2901_slice_if dut_if ();
    am2901_slice_if lo_if ();
    am2901_slice_if hi_if ();
    am2901_slice dut (.clock(clock), .reset_n(reset_n), .bus(dut_if));
    am2901_slice lo (.clock(clock), .reset_n(reset_n), .bus(lo_if));
    am2901_slice hi (.clock(clock), .reset_n(reset_n), .bus(hi_if));
    assign hi_if.cin = lo_if.cout;

    typedef struct {
        logic [2:0] src, op, dest;
        logic [3:0] din, a, b;
        logic cin;
        logic [3:0] shin;
        logic [11:0] exp;
        logic chk_sh;
        logic [3:0] sh;
        string tag;
    } stim_t;
    typedef struct {
        logic [11:0] v;
        logic chk_sh;
        logic [3:0] sh;
        string tag;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // exp packs {yout, cout, ovr, f0, f3}; shin packs {ram3_in, ram0_in, q3_in, q0_in}
    function automatic stim_t mk(input string tag, input logic [2:0] src, input logic [2:0] op,
                                 input logic [2:0] dest, input logic [3:0] din, input logic [3:0] a,
                                 input logic [3:0] b, input logic cin, input logic [3:0] shin,
                                 input logic [7:0] exp, input logic chk_sh = 1'b0,
                                 input logic [3:0] sh = 4'd0);
        stim_t s;
        s.src = src; s.op = op; s.dest = dest; s.din = din; s.a = a; s.b = b; s.cin = cin;
        s.shin = shin; s.exp = {4'd0, exp}; s.chk_sh = chk_sh; s.sh = sh; s.tag = tag;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        @(negedge clock);
        dut_if.src = s.src; dut_if.op = s.op; dut_if.dest = s.dest;
        dut_if.din = s.din; dut_if.a_addr = s.a; dut_if.b_addr = s.b; dut_if.cin = s.cin;
        {dut_if.ram3_in, dut_if.ram0_in, dut_if.q3_in, dut_if.q0_in} = s.shin;
        sb.push_back('{s.exp, s.chk_sh, s.sh, s.tag});
        #1;
    endtask

    task automatic test_reset();
        stim_t t[$];
        exp_t e;
        logic [11:0] got;
        dut_if.src = 3'd7; dut_if.op = 3'd0; dut_if.dest = 3'd3; dut_if.din = 4'h9;
        dut_if.a_addr = 4'd0; dut_if.b_addr = 4'd2; dut_if.cin = 1'b0;
        {dut_if.ram3_in, dut_if.ram0_in, dut_if.q3_in, dut_if.q0_in} = 4'd0;
        reset_n = 1'b0;
        @(negedge clock);
        dut_if.dest = 3'd0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        t.push_back(mk("rst_ab", 3'd1, 3'd3, 3'd1, 4'h0, 4'd2, 4'd5, 1'b0, 4'd0, 8'h02));
        t.push_back(mk("rst_q", 3'd2, 3'd3, 3'd1, 4'h0, 4'd0, 4'd0, 1'b0, 4'd0, 8'h02));
        t.push_back(mk("rst_a15", 3'd4, 3'd3, 3'd1, 4'h0, 4'd15, 4'd0, 1'b0, 4'd0, 8'h02));
        t.push_back(mk("rst_b2", 3'd3, 3'd3, 3'd1, 4'h0, 4'd0, 4'd2, 1'b0, 4'd0, 8'h02));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            got = {4'd0, dut_if.yout, dut_if.cout, dut_if.ovr, dut_if.f0, dut_if.f3};
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.tag, got, e.v);
            end
        end
    endtask

    task automatic test_alu();
        stim_t t[$];
        exp_t e;
        logic [11:0] got;
        t.push_back(mk("ld_r2", 3'd7, 3'd0, 3'd3, 4'h5, 4'd0, 4'd2, 1'b0, 4'd0, 8'h50));
        t.push_back(mk("add_c", 3'd5, 3'd0, 3'd1, 4'hC, 4'd2, 4'd0, 1'b0, 4'd0, 8'h18));
        t.push_back(mk("ld_q7", 3'd7, 3'd0, 3'd0, 4'h7, 4'd0, 4'd0, 1'b0, 4'd0, 8'h70));
        t.push_back(mk("subr", 3'd2, 3'd1, 3'd1, 4'h0, 4'd0, 4'd0, 1'b1, 4'd0, 8'h78));
        t.push_back(mk("subs", 3'd2, 3'd2, 3'd1, 4'h0, 4'd0, 4'd0, 1'b1, 4'd0, 8'h91));
        t.push_back(mk("add_ovr", 3'd7, 3'd0, 3'd1, 4'h7, 4'd0, 4'd0, 1'b1, 4'd0, 8'h85));
        t.push_back(mk("wrap0", 3'd7, 3'd0, 3'd1, 4'hF, 4'd0, 4'd0, 1'b1, 4'd0, 8'h0A));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            got = {4'd0, dut_if.yout, dut_if.cout, dut_if.ovr, dut_if.f0, dut_if.f3};
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.tag, got, e.v);
            end
        end
    endtask

    task automatic test_shift();
        stim_t t[$];
        exp_t e;
        logic [11:0] got;
        logic [3:0] shg;
        t.push_back(mk("ld_r1", 3'd7, 3'd0, 3'd3, 4'hA, 4'd0, 4'd1, 1'b0, 4'd0, 8'hA1));
        t.push_back(mk("ld_q3", 3'd7, 3'd0, 3'd0, 4'h3, 4'd0, 4'd0, 1'b0, 4'd0, 8'h30));
        t.push_back(mk("ramqd", 3'd3, 3'd3, 3'd4, 4'h0, 4'd0, 4'd1, 1'b0, 4'b1000, 8'hA1, 1'b1, 4'b1001));
        t.push_back(mk("rd_r1_d", 3'd3, 3'd3, 3'd1, 4'h0, 4'd0, 4'd1, 1'b0, 4'd0, 8'hD1));
        t.push_back(mk("rd_q_1", 3'd2, 3'd3, 3'd1, 4'h0, 4'd0, 4'd0, 1'b0, 4'd0, 8'h10));
        t.push_back(mk("ramqu", 3'd3, 3'd3, 3'd6, 4'h0, 4'd0, 4'd1, 1'b0, 4'b0101, 8'hD1, 1'b1, 4'b1101));
        t.push_back(mk("rd_r1_b", 3'd3, 3'd3, 3'd1, 4'h0, 4'd0, 4'd1, 1'b0, 4'd0, 8'hB1));
        t.push_back(mk("rd_q_3", 3'd2, 3'd3, 3'd1, 4'h0, 4'd0, 4'd0, 1'b0, 4'd0, 8'h30));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            got = {4'd0, dut_if.yout, dut_if.cout, dut_if.ovr, dut_if.f0, dut_if.f3};
            shg = {dut_if.ram3_out, dut_if.ram0_out, dut_if.q3_out, dut_if.q0_out};
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.tag, got, e.v);
            end
            if (e.chk_sh) begin
                checks++;
                if (shg !== e.sh) begin
                    failures++;
                    $display("FAIL %s_shift_out: got %b expected %b", e.tag, shg, e.sh);
                end
            end
        end
    endtask

    task automatic test_rama_logic();
        stim_t t[$];
        exp_t e;
        logic [11:0] got;
        t.push_back(mk("ld_r3", 3'd7, 3'd0, 3'd3, 4'h6, 4'd0, 4'd3, 1'b0, 4'd0, 8'h60));
        t.push_back(mk("ld_r4", 3'd7, 3'd0, 3'd3, 4'h5, 4'd0, 4'd4, 1'b0, 4'd0, 8'h50));
        t.push_back(mk("rama_xor", 3'd1, 3'd6, 3'd2, 4'h0, 4'd3, 4'd4, 1'b0, 4'd0, 8'h60));
        t.push_back(mk("rd_r4", 3'd3, 3'd3, 3'd1, 4'h0, 4'd0, 4'd4, 1'b0, 4'd0, 8'h30));
        t.push_back(mk("ld_q5", 3'd7, 3'd0, 3'd0, 4'h5, 4'd0, 4'd0, 1'b0, 4'd0, 8'h50));
        t.push_back(mk("notrs", 3'd6, 3'd5, 3'd1, 4'h6, 4'd0, 4'd0, 1'b0, 4'd0, 8'h10));
        t.push_back(mk("and", 3'd6, 3'd4, 3'd1, 4'h6, 4'd0, 4'd0, 1'b0, 4'd0, 8'h40));
        t.push_back(mk("exnor", 3'd6, 3'd7, 3'd1, 4'h6, 4'd0, 4'd0, 1'b0, 4'd0, 8'hC1));
        t.push_back(mk("or", 3'd6, 3'd3, 3'd1, 4'h6, 4'd0, 4'd0, 1'b0, 4'd0, 8'h70));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            got = {4'd0, dut_if.yout, dut_if.cout, dut_if.ovr, dut_if.f0, dut_if.f3};
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.tag, got, e.v);
            end
        end
    endtask

    task automatic test_hazard();
        stim_t t[$];
        exp_t e;
        logic [11:0] got;
        t.push_back(mk("ld_r2", 3'd7, 3'd0, 3'd3, 4'h5, 4'd0, 4'd2, 1'b0, 4'd0, 8'h50));
        t.push_back(mk("haz_old", 3'd1, 3'd0, 3'd3, 4'h0, 4'd2, 4'd2, 1'b0, 4'd0, 8'hA5));
        t.push_back(mk("haz_new", 3'd1, 3'd0, 3'd1, 4'h0, 4'd2, 4'd2, 1'b0, 4'd0, 8'h4C));
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            got = {4'd0, dut_if.yout, dut_if.cout, dut_if.ovr, dut_if.f0, dut_if.f3};
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.tag, got, e.v);
            end
        end
    endtask

    // exp packs {hi.yout, lo.yout, hi.cout}
    task automatic test_cascade();
        logic [3:0] lo_d [3] = '{4'hF, 4'hF, 4'h3};
        logic [3:0] hi_d [3] = '{4'hF, 4'h0, 4'h1};
        logic lo_c [3] = '{1'b1, 1'b1, 1'b0};
        logic [11:0] ex [3] = '{12'h001, 12'h020, 12'h026};
        exp_t e;
        logic [11:0] got;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            lo_if.din = lo_d[i];
            hi_if.din = hi_d[i];
            lo_if.cin = lo_c[i];
            sb.push_back('{ex[i], 1'b0, 4'd0, $sformatf("cascade%0d", i)});
            #1;
            e = sb.pop_front();
            got = {3'd0, hi_if.yout, lo_if.yout, hi_if.cout};
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.tag, got, e.v);
            end
        end
    endtask

    initial begin
        lo_if.src = 3'd7; lo_if.op = 3'd0; lo_if.dest = 3'd1; lo_if.din = 4'd0; lo_if.cin = 1'b0;
        lo_if.a_addr = 4'd0; lo_if.b_addr = 4'd0;
        {lo_if.ram3_in, lo_if.ram0_in, lo_if.q3_in, lo_if.q0_in} = 4'd0;
        hi_if.src = 3'd7; hi_if.op = 3'd0; hi_if.dest = 3'd1; hi_if.din = 4'd0;
        hi_if.a_addr = 4'd0; hi_if.b_addr = 4'd0;
        {hi_if.ram3_in, hi_if.ram0_in, hi_if.q3_in, hi_if.q0_in} = 4'd0;
        test_reset();
        test_alu();
        test_shift();
        test_rama_logic();
        test_hazard();
        test_cascade();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
